// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program sequencer.
package pc_sequencer_pkg;

  // Raw state encodings, kept as plain constants so legacy code can still
  // compare against them; the enum below takes these values.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_MEM   = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ARMED = ST_ARMED,
    S_RUN   = ST_RUN,
    S_MEM   = ST_MEM,
    S_HALT  = ST_HALT
  } seq_state_t;

  // Next-PC source selected by the FSM.
  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_OFFSET = 2'd2,
    PC_LOAD   = 2'd3
  } pc_sel_t;

  // Program entry points, indexed by prog_sel.
  localparam int unsigned START_ADDR [4] = '{0, 128, 256, 384};

  // Entry address for a given program select.
  function automatic int unsigned entry_addr(input logic [1:0] sel);
    return START_ADDR[sel];
  endfunction

endpackage

// File: rtl/pc_sequencer_pc_next.sv
// Combinational next-PC mux: hold, increment, signed offset, or entry load.
// All arithmetic wraps modulo 2^T.
module pc_sequencer_pc_next
  import pc_sequencer_pkg::*;
#(
  parameter int T = 10,
  parameter int W = 8
) (
  input  logic [T-1:0] pc,
  input  logic [T-1:0] entry,
  input  logic [W-1:0] offset,
  input  pc_sel_t      sel,
  output logic [T-1:0] pc_next,
  output logic [T-1:0] pc_p1
);

  logic [T-1:0] offset_ext;

  // Sign-extend the branch offset to PC width (assumes T > W).
  always_comb begin
    offset_ext = {{(T-W){offset[W-1]}}, offset};
  end

  // Select the next PC; carries out of bit T-1 are dropped, giving the wrap.
  always_comb begin
    pc_p1 = pc + T'(1);
    case (sel)
      PC_INC:    pc_next = pc_p1;
      PC_OFFSET: pc_next = pc + offset_ext;
      PC_LOAD:   pc_next = entry;
      default:   pc_next = pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: PC ownership, Start/Done handshake, branch resolution
// and the one-cycle stall for synchronous data-memory reads.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | out of reset, waiting for Start
//   ARMED | entry address loaded, waiting for Start to drop
//   RUN   | executing one instruction per cycle
//   MEM   | second cycle of LDW; load write-back commits here
//   HALT  | program finished, Done asserted, waiting for next Start
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int T = 10,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         Start,
  input  logic [1:0]   prog_sel,
  input  logic         Done_in,
  input  logic         BranchEZ,
  input  logic         BranchNZ,
  input  logic         BranchAlways,
  input  logic         mem_read,
  input  logic         acc_zero,
  input  logic [W-1:0] RegOutA,
  output logic [T-1:0] ProgCtr,
  output logic [T-1:0] ProgCtr_p1,
  output logic         commit_en,
  output logic         Done,
  output logic         busy
);

  seq_state_t   state_q, state_d;
  logic [T-1:0] pc_q, pc_d;
  logic         done_q, done_d;
  logic [T-1:0] entry;
  logic         taken;
  pc_sel_t      pc_sel;

  // Branch condition and entry address for the current prog_sel.
  always_comb begin
    taken = BranchAlways | (BranchEZ & acc_zero) | (BranchNZ & ~acc_zero);
    entry = T'(entry_addr(prog_sel));
  end

  pc_sequencer_pc_next #(
    .T (T),
    .W (W)
  ) u_pc_next (
    .pc      (pc_q),
    .entry   (entry),
    .offset  (RegOutA),
    .sel     (pc_sel),
    .pc_next (pc_d),
    .pc_p1   (ProgCtr_p1)
  );

  // FSM next-state, PC source and commit qualification.
  // Start always wins so an abort never lets the current instruction commit.
  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    pc_sel    = PC_HOLD;
    commit_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          pc_sel  = PC_LOAD;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (Start) begin
          pc_sel = PC_LOAD;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (Start) begin
          pc_sel  = PC_LOAD;
          state_d = S_ARMED;
        end else if (Done_in) begin
          done_d  = 1'b1;
          state_d = S_HALT;
        end else if (mem_read) begin
          state_d = S_MEM;
        end else begin
          commit_en = 1'b1;
          pc_sel    = taken ? PC_OFFSET : PC_INC;
        end
      end
      S_MEM: begin
        if (Start) begin
          pc_sel  = PC_LOAD;
          state_d = S_ARMED;
        end else begin
          commit_en = 1'b1;
          pc_sel    = PC_INC;
          state_d   = S_RUN;
        end
      end
      S_HALT: begin
        if (Start) begin
          pc_sel  = PC_LOAD;
          done_d  = 1'b0;
          state_d = S_ARMED;
        end
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, PC and Done registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  // Output views of the registered state.
  always_comb begin
    ProgCtr = pc_q;
    Done    = done_q;
    busy    = (state_q == S_RUN) || (state_q == S_MEM);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Start;
  logic [1:0] prog_sel;
  logic       Done_in, BranchEZ, BranchNZ, BranchAlways, mem_read, acc_zero;
  logic [7:0] RegOutA;
  logic [9:0] ProgCtr, ProgCtr_p1;
  logic       commit_en, Done, busy;

  int n_vec = 0;
  int n_err = 0;

  pc_sequencer #(.T(10), .W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Start        (Start),
    .prog_sel     (prog_sel),
    .Done_in      (Done_in),
    .BranchEZ     (BranchEZ),
    .BranchNZ     (BranchNZ),
    .BranchAlways (BranchAlways),
    .mem_read     (mem_read),
    .acc_zero     (acc_zero),
    .RegOutA      (RegOutA),
    .ProgCtr      (ProgCtr),
    .ProgCtr_p1   (ProgCtr_p1),
    .commit_en    (commit_en),
    .Done         (Done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Start = 0; prog_sel = 0; Done_in = 0; BranchEZ = 0; BranchNZ = 0;
    BranchAlways = 0; mem_read = 0; acc_zero = 0; RegOutA = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Start pulse for one cycle, then drop it; returns in the first RUN cycle.
  task automatic launch(input logic [1:0] sel);
    Start = 1; prog_sel = sel;
    tick();
    Start = 0;
    tick();
  endtask

  task automatic jump(input logic [7:0] off);
    BranchAlways = 1; RegOutA = off;
    tick();
    BranchAlways = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (ProgCtr !== 10'd0) begin n_err++; $display("FAIL reset_pc got %0d want 0", ProgCtr); end
    n_vec++; if (Done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", Done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL reset_commit got %b want 0", commit_en); end
    n_vec++; if (ProgCtr_p1 !== 10'd1) begin n_err++; $display("FAIL reset_p1 got %0d want 1", ProgCtr_p1); end
  endtask

  task automatic test_start();
    do_reset();
    Start = 1; prog_sel = 2;
    tick();
    n_vec++; if (ProgCtr !== 10'd256) begin n_err++; $display("FAIL armed_pc got %0d want 256", ProgCtr); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL armed_busy got %b want 0", busy); end
    tick();
    Start = 0;
    #1;
    n_vec++; if (ProgCtr !== 10'd256) begin n_err++; $display("FAIL armed_hold_pc got %0d want 256", ProgCtr); end
    n_vec++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL armed_commit got %b want 0", commit_en); end
    tick();
    n_vec++; if (ProgCtr !== 10'd256) begin n_err++; $display("FAIL run_first_pc got %0d want 256", ProgCtr); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL run_busy got %b want 1", busy); end
    n_vec++; if (commit_en !== 1'b1) begin n_err++; $display("FAIL run_commit got %b want 1", commit_en); end
    tick();
    n_vec++; if (ProgCtr !== 10'd257) begin n_err++; $display("FAIL run_inc_pc got %0d want 257", ProgCtr); end
  endtask

  task automatic test_branch();
    do_reset();
    launch(2);
    jump(8'd44);
    n_vec++; if (ProgCtr !== 10'd300) begin n_err++; $display("FAIL br_setup got %0d want 300", ProgCtr); end
    BranchNZ = 1; acc_zero = 0; RegOutA = 8'hFC;
    #1;
    n_vec++; if (commit_en !== 1'b1) begin n_err++; $display("FAIL br_commit got %b want 1", commit_en); end
    tick();
    BranchNZ = 0;
    n_vec++; if (ProgCtr !== 10'd296) begin n_err++; $display("FAIL bnz_taken got %0d want 296", ProgCtr); end
    jump(8'd4);
    BranchNZ = 1; acc_zero = 1; RegOutA = 8'hFC;
    tick();
    BranchNZ = 0;
    n_vec++; if (ProgCtr !== 10'd301) begin n_err++; $display("FAIL bnz_not_taken got %0d want 301", ProgCtr); end
    BranchEZ = 1; acc_zero = 1; RegOutA = 8'h10;
    tick();
    n_vec++; if (ProgCtr !== 10'd317) begin n_err++; $display("FAIL bez_taken got %0d want 317", ProgCtr); end
    acc_zero = 0;
    tick();
    n_vec++; if (ProgCtr !== 10'd318) begin n_err++; $display("FAIL bez_not_taken got %0d want 318", ProgCtr); end
    clear_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    launch(0);
    jump(8'hFF);
    n_vec++; if (ProgCtr !== 10'd1023) begin n_err++; $display("FAIL neg_wrap got %0d want 1023", ProgCtr); end
    n_vec++; if (ProgCtr_p1 !== 10'd0) begin n_err++; $display("FAIL p1_wrap got %0d want 0", ProgCtr_p1); end
    tick();
    n_vec++; if (ProgCtr !== 10'd0) begin n_err++; $display("FAIL inc_wrap got %0d want 0", ProgCtr); end
    jump(8'hE8);
    n_vec++; if (ProgCtr !== 10'd1000) begin n_err++; $display("FAIL wrap_setup got %0d want 1000", ProgCtr); end
    jump(8'h7F);
    n_vec++; if (ProgCtr !== 10'd103) begin n_err++; $display("FAIL pos_wrap got %0d want 103", ProgCtr); end
  endtask

  task automatic test_mem();
    do_reset();
    launch(0);
    jump(8'd10);
    mem_read = 1;
    #1;
    n_vec++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL ldw_commit got %b want 0", commit_en); end
    tick();
    mem_read = 0;
    #1;
    n_vec++; if (ProgCtr !== 10'd10) begin n_err++; $display("FAIL mem_pc got %0d want 10", ProgCtr); end
    n_vec++; if (commit_en !== 1'b1) begin n_err++; $display("FAIL mem_commit got %b want 1", commit_en); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mem_busy got %b want 1", busy); end
    tick();
    n_vec++; if (ProgCtr !== 10'd11) begin n_err++; $display("FAIL mem_next_pc got %0d want 11", ProgCtr); end
  endtask

  task automatic test_done();
    do_reset();
    launch(0);
    jump(8'd50);
    Done_in = 1;
    #1;
    n_vec++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL dne_commit got %b want 0", commit_en); end
    n_vec++; if (Done !== 1'b0) begin n_err++; $display("FAIL dne_early_done got %b want 0", Done); end
    tick();
    Done_in = 0;
    n_vec++; if (Done !== 1'b1) begin n_err++; $display("FAIL halt_done got %b want 1", Done); end
    n_vec++; if (ProgCtr !== 10'd50) begin n_err++; $display("FAIL halt_pc got %0d want 50", ProgCtr); end
    n_vec++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL halt_commit got %b want 0", commit_en); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL halt_busy got %b want 0", busy); end
    tick();
    n_vec++; if (ProgCtr !== 10'd50 || Done !== 1'b1) begin n_err++; $display("FAIL halt_hold got pc=%0d done=%b want pc=50 done=1", ProgCtr, Done); end
    Start = 1; prog_sel = 1;
    tick();
    Start = 0;
    n_vec++; if (Done !== 1'b0) begin n_err++; $display("FAIL restart_done got %b want 0", Done); end
    n_vec++; if (ProgCtr !== 10'd128) begin n_err++; $display("FAIL restart_pc got %0d want 128", ProgCtr); end
    tick();
    n_vec++; if (busy !== 1'b1 || ProgCtr !== 10'd128) begin n_err++; $display("FAIL restart_run got busy=%b pc=%0d want busy=1 pc=128", busy, ProgCtr); end
  endtask

  task automatic test_abort();
    do_reset();
    launch(0);
    jump(8'd10);
    mem_read = 1;
    tick();
    mem_read = 0; Start = 1; prog_sel = 3;
    #1;
    n_vec++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL mem_abort_commit got %b want 0", commit_en); end
    tick();
    n_vec++; if (ProgCtr !== 10'd384 || busy !== 1'b0) begin n_err++; $display("FAIL mem_abort got pc=%0d busy=%b want pc=384 busy=0", ProgCtr, busy); end
    Start = 0;
    tick();
    n_vec++; if (ProgCtr !== 10'd384 || busy !== 1'b1) begin n_err++; $display("FAIL abort_rerun got pc=%0d busy=%b want pc=384 busy=1", ProgCtr, busy); end
    Start = 1; prog_sel = 1; BranchAlways = 1; RegOutA = 8'd5;
    #1;
    n_vec++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL run_abort_commit got %b want 0", commit_en); end
    tick();
    clear_inputs();
    n_vec++; if (ProgCtr !== 10'd128 || busy !== 1'b0) begin n_err++; $display("FAIL run_abort got pc=%0d busy=%b want pc=128 busy=0", ProgCtr, busy); end
  endtask

  task automatic test_async_reset();
    do_reset();
    launch(0);
    Done_in = 1;
    tick();
    Done_in = 0;
    #2 rst_n = 0;
    #1;
    n_vec++; if (ProgCtr !== 10'd0 || Done !== 1'b0) begin n_err++; $display("FAIL areset_halt got pc=%0d done=%b want pc=0 done=0", ProgCtr, Done); end
    n_vec++; if (commit_en !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL areset_halt_ctl got commit=%b busy=%b want 0 0", commit_en, busy); end
    @(negedge clk) rst_n = 1;
    tick();
    launch(2);
    tick();
    n_vec++; if (ProgCtr !== 10'd257) begin n_err++; $display("FAIL areset_setup got %0d want 257", ProgCtr); end
    #2 rst_n = 0;
    #1;
    n_vec++; if (ProgCtr !== 10'd0 || busy !== 1'b0 || commit_en !== 1'b0) begin n_err++; $display("FAIL areset_run got pc=%0d busy=%b commit=%b want 0 0 0", ProgCtr, busy, commit_en); end
    tick();
    n_vec++; if (ProgCtr !== 10'd0 || busy !== 1'b0) begin n_err++; $display("FAIL areset_hold got pc=%0d busy=%b want 0 0", ProgCtr, busy); end
    rst_n = 1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_start();
    test_branch();
    test_wrap();
    test_mem();
    test_done();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
